// File: rtl/neuron_accumulator.sv
// Neuron accumulation stage: sums a stream of signed terms onto a preloaded
// bias through a carry-lookahead adder, and hands one pre-activation sum
// per job to the activation stage over a valid/ready handshake.

// Carry-lookahead adder built from 4-bit lookahead groups. Each group's
// carry-in comes from the previous group's generate/propagate terms.
// WIDTH must be a multiple of 4. The final carry-out is not produced
// because this datapath has no use for it.
module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-2:0] gen;
    logic [WIDTH-1:0] prop;
    logic [NG-1:0]    group_carry;

    assign gen            = in1[WIDTH-2:0] & in2[WIDTH-2:0];
    assign prop           = in1 ^ in2;
    assign group_carry[0] = carry_in;

    for (genvar g = 0; g < NG; g++) begin : grp
        localparam int B = 4 * g;
        logic [3:0] c;

        assign c[0] = group_carry[g];
        assign c[1] = gen[B] | (prop[B] & c[0]);
        assign c[2] = gen[B+1] | (prop[B+1] & gen[B])
                    | (prop[B+1] & prop[B] & c[0]);
        assign c[3] = gen[B+2] | (prop[B+2] & gen[B+1])
                    | (prop[B+2] & prop[B+1] & gen[B])
                    | (prop[B+2] & prop[B+1] & prop[B] & c[0]);
        assign sum[B+3:B] = prop[B+3:B] ^ c;

        if (g < NG - 1) begin : look
            logic grp_g;
            logic grp_p;
            assign grp_g = gen[B+3] | (prop[B+3] & gen[B+2])
                         | (prop[B+3] & prop[B+2] & gen[B+1])
                         | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B]);
            assign grp_p = &prop[B+3:B];
            assign group_carry[g+1] = grp_g | (grp_p & c[0]);
        end
    end
endmodule

module neuron_accumulator #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] bias,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] count;
    logic             ovf;
    logic [WIDTH-1:0] adder_sum;
    logic [WIDTH-1:0] acc_next;
    logic             beat_ovf;
    logic             accept;

    cla_adder #(.WIDTH(WIDTH)) u_adder (
        .in1      (acc),
        .in2      (in_data),
        .carry_in (1'b0),
        .sum      (adder_sum)
    );

    // Signed overflow from operand/result sign bits, plus the optional clamp
    // toward the sign of the operands (both operands share a sign on overflow).
    always_comb begin
        beat_ovf = (acc[WIDTH-1] == in_data[WIDTH-1]) &&
                   (adder_sum[WIDTH-1] != acc[WIDTH-1]);
        acc_next = adder_sum;
        if (SAT && beat_ovf) begin
            acc_next = acc[WIDTH-1] ? MIN_NEG : MAX_POS;
        end
    end

    assign accept = in_valid && (state == ACCUM);

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; start is only honoured in IDLE.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (count == LEN_W'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Accumulator, remaining-term count and sticky overflow for the job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc   <= bias;
            count <= len;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_next;
            count <= count - LEN_W'(1);
            if (beat_ovf) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_sum      = acc;
    assign out_overflow = ovf;
endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: runs a wrapping and a
// saturating instance side by side on identical stimulus.
module tb_neuron_accumulator;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [31:0] bias;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_w, out_overflow_w, out_valid_w, busy_w;
    logic [31:0] out_sum_w;
    logic        in_ready_s, out_overflow_s, out_valid_s, busy_s;
    logic [31:0] out_sum_s;

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0]       len;
        logic [31:0]      bias;
        logic [3:0][31:0] terms;
        logic [31:0]      exp_wrap;
        logic [31:0]      exp_sat;
        logic             exp_ovf_wrap;
        logic             exp_ovf_sat;
    } vec_t;

    vec_t vecs [5];

    neuron_accumulator #(.WIDTH(32), .LEN_W(8), .SAT(1'b0)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .bias         (bias),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready_w),
        .out_sum      (out_sum_w),
        .out_overflow (out_overflow_w),
        .out_valid    (out_valid_w),
        .out_ready    (out_ready),
        .busy         (busy_w)
    );

    neuron_accumulator #(.WIDTH(32), .LEN_W(8), .SAT(1'b1)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .bias         (bias),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready_s),
        .out_sum      (out_sum_s),
        .out_overflow (out_overflow_s),
        .out_valid    (out_valid_s),
        .out_ready    (out_ready),
        .busy         (busy_s)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] l, input logic [31:0] b,
                                input logic [31:0] t0, input logic [31:0] t1,
                                input logic [31:0] t2, input logic [31:0] t3,
                                input logic [31:0] ew, input logic [31:0] es,
                                input logic ow, input logic os);
        vec_t v;
        v.len          = l;
        v.bias         = b;
        v.terms[0]     = t0;
        v.terms[1]     = t1;
        v.terms[2]     = t2;
        v.terms[3]     = t3;
        v.exp_wrap     = ew;
        v.exp_sat      = es;
        v.exp_ovf_wrap = ow;
        v.exp_ovf_sat  = os;
        return v;
    endfunction

    // One complete job with back-to-back terms, checks latency, result and
    // the return to IDLE after the output handshake.
    task automatic applyStimulus(input vec_t v, input string tag);
        start = 1'b1;
        len   = v.len;
        bias  = v.bias;
        tick();
        start = 1'b0;
        if (v.len != 8'd0) begin
            checkOutput({tag, " in_ready_accum"}, 32'(in_ready_w), 32'd1);
        end
        for (int k = 0; k < int'(v.len); k++) begin
            in_valid = 1'b1;
            in_data  = v.terms[k];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput({tag, " out_valid_latency"}, 32'(out_valid_w), 32'd1);
        checkOutput({tag, " sum_wrap"}, out_sum_w, v.exp_wrap);
        checkOutput({tag, " sum_sat"}, out_sum_s, v.exp_sat);
        checkOutput({tag, " ovf_wrap"}, 32'(out_overflow_w), 32'(v.exp_ovf_wrap));
        checkOutput({tag, " ovf_sat"}, 32'(out_overflow_s), 32'(v.exp_ovf_sat));
        checkOutput({tag, " in_ready_done"}, 32'(in_ready_w), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, " busy_idle"}, 32'(busy_w), 32'd0);
        checkOutput({tag, " in_ready_idle"}, 32'(in_ready_s), 32'd0);
    endtask

    initial begin
        bit seen_valid;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        len         = '0;
        bias        = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;

        vecs[0] = mk(8'd3, 32'd10, 32'd5, 32'hFFFF_FFFE, 32'd7, 32'd0,
                     32'd20, 32'd20, 1'b0, 1'b0);
        vecs[1] = mk(8'd2, 32'h7FFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd0,
                     32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        vecs[2] = mk(8'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0,
                     32'h8000_0004, 32'h8000_0005, 1'b1, 1'b1);
        vecs[3] = mk(8'd1, 32'hFFFF_FF9C, 32'd100, 32'd0, 32'd0, 32'd0,
                     32'd0, 32'd0, 1'b0, 1'b0);
        vecs[4] = mk(8'd4, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0);

        // Reset state.
        #1;
        checkOutput("reset sum", out_sum_w, 32'd0);
        checkOutput("reset ovf", 32'(out_overflow_w), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid_s), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready_w), 32'd0);
        checkOutput("reset busy", 32'(busy_s), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-length job with the result stalled downstream.
        start = 1'b1;
        len   = 8'd0;
        bias  = 32'hFFFF_FFF6;
        tick();
        start = 1'b0;
        checkOutput("zlen out_valid", 32'(out_valid_w), 32'd1);
        checkOutput("zlen sum", out_sum_w, 32'hFFFF_FFF6);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("zlen stall%0d sum", k), out_sum_s, 32'hFFFF_FFF6);
            checkOutput($sformatf("zlen stall%0d valid", k), 32'(out_valid_s), 32'd1);
            checkOutput($sformatf("zlen stall%0d busy", k), 32'(busy_w), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("zlen busy after", 32'(busy_w), 32'd0);
        checkOutput("zlen valid after", 32'(out_valid_w), 32'd0);

        // Toggling in_valid with start pulses during the idle beats.
        start = 1'b1;
        len   = 8'd4;
        bias  = 32'd100;
        tick();
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0) begin
                start    = 1'b0;
                in_valid = 1'b1;
                in_data  = 32'(k / 2 + 1);
            end else begin
                start    = 1'b1;
                len      = 8'd0;
                bias     = 32'd999;
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
            end
            tick();
            if (k == 5) begin
                checkOutput("stall 3 beats valid", 32'(out_valid_w), 32'd0);
                checkOutput("stall 3 beats sum", out_sum_w, 32'd106);
            end
            if (k == 6) begin
                checkOutput("stall 4 beats valid", 32'(out_valid_w), 32'd1);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("stall sum_wrap", out_sum_w, 32'd110);
        checkOutput("stall sum_sat", out_sum_s, 32'd110);
        start = 1'b1;
        len   = 8'd3;
        bias  = 32'd999;
        tick();
        start = 1'b0;
        checkOutput("done start sum", out_sum_w, 32'd110);
        checkOutput("done start valid", 32'(out_valid_w), 32'd1);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        checkOutput("handshake start ignored", 32'(busy_w), 32'd0);
        tick();
        checkOutput("still idle", 32'(busy_s), 32'd0);

        // Reset in the middle of a job.
        start = 1'b1;
        len   = 8'd5;
        bias  = 32'd7;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k + 1);
            tick();
        end
        in_data = 32'd3;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset sum", out_sum_w, 32'd0);
        checkOutput("midreset sum_sat", out_sum_s, 32'd0);
        checkOutput("midreset ovf", 32'(out_overflow_w), 32'd0);
        checkOutput("midreset valid", 32'(out_valid_w), 32'd0);
        checkOutput("midreset in_ready", 32'(in_ready_w), 32'd0);
        checkOutput("midreset busy", 32'(busy_w), 32'd0);
        tick();
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid_w || out_valid_s || busy_w) seen_valid = 1'b1;
        end
        in_valid = 1'b0;
        checkOutput("aborted job never valid", 32'(seen_valid), 32'd0);
        applyStimulus(mk(8'd1, 32'd0, 32'd42, 32'd0, 32'd0, 32'd0,
                         32'd42, 32'd42, 1'b0, 1'b0), "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
